// File: rtl/doorlock_pkg.sv
// Shared types and constants for the doorlock sequencing FSM.
package doorlock_pkg;

    // BCD digit width and number of digit keys on the keypad.
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned N_KEYS  = 10;

    // FSM state encodings as seen on state_o.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENTRY    = 3'd1,
        CHG_AUTH = 3'd2,
        CHG_NEW  = 3'd3,
        LOCKOUT  = 3'd4
    } state_e;

endpackage

// File: rtl/doorlock_ctrl_key_enc.sv
// One-hot digit key to BCD encoder; flags a key only when exactly one bit is set.
module key_enc
    import doorlock_pkg::*;
(
    input  logic [N_KEYS-1:0]  bt_i,
    output logic [DIGIT_W-1:0] bcd_o,
    output logic               valid_o
);

    logic [3:0] hits;

    // Count set bits and remember the index of the (last) set one.
    always_comb begin
        bcd_o = '0;
        hits  = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (bt_i[i]) begin
                bcd_o = DIGIT_W'(i);
                hits  = hits + 4'd1;
            end
        end
        valid_o = (hits == 4'd1);
    end

endmodule

// File: rtl/doorlock_ctrl.sv
// Doorlock sequencing FSM: code entry, verification, password change and lockout.
module doorlock_ctrl
    import doorlock_pkg::*;
#(
    parameter int unsigned               PW_LEN   = 4,
    parameter int unsigned               MAX_FAIL = 3,
    parameter logic [31:0]               T_IDLE   = 32'd250_000_000,
    parameter logic [31:0]               T_LOCK   = 32'd500_000_000,
    parameter logic [DIGIT_W*PW_LEN-1:0] INIT_PW  = 16'h1234
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [9:0]  bt_i,
    input  logic        btstar_i,
    output logic        open_o,
    output logic        err_o,
    output logic        lock_o,
    output logic        chg_o,
    output logic [3:0]  cnt_o,
    output logic [2:0]  state_o
);

    localparam int unsigned BW          = DIGIT_W * PW_LEN;
    localparam logic [3:0]  CNT_FULL    = 4'(PW_LEN);
    localparam logic [3:0]  FAIL_LIM    = 4'(MAX_FAIL);
    localparam logic [31:0] IDLE_RELOAD = T_IDLE - 32'd1;
    localparam logic [31:0] LOCK_RELOAD = T_LOCK - 32'd1;

    state_e               state_q, state_d;
    logic [BW-1:0]        entry_q, entry_d;
    logic [BW-1:0]        pw_q, pw_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [3:0]           fail_q, fail_d;
    logic [31:0]          timer_q, timer_d;
    logic                 open_q, open_d;
    logic                 err_q, err_d;

    logic [DIGIT_W-1:0]   key_bcd;
    logic                 key_valid;
    logic                 dig;
    logic                 match;
    logic [3:0]           fail_inc;

    key_enc u_key_enc (
        .bt_i    (bt_i),
        .bcd_o   (key_bcd),
        .valid_o (key_valid)
    );

    // A star in the same cycle drops any digit.
    assign dig      = key_valid & ~btstar_i;
    assign match    = (cnt_q == CNT_FULL) && (entry_q == pw_q);
    assign fail_inc = fail_q + 4'd1;

    // State register and datapath registers, async active-low reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            entry_q <= '0;
            pw_q    <= INIT_PW;
            cnt_q   <= '0;
            fail_q  <= '0;
            timer_q <= '0;
            open_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            pw_q    <= pw_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
            open_q  <= open_d;
            err_q   <= err_d;
        end
    end

    // Next-state, entry buffer, timer and fail-counter logic.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        pw_d    = pw_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        open_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (btstar_i) begin
                    state_d = CHG_AUTH;
                    entry_d = '0;
                    cnt_d   = '0;
                    timer_d = IDLE_RELOAD;
                end else if (dig) begin
                    state_d = ENTRY;
                    entry_d = BW'(key_bcd);
                    cnt_d   = 4'd1;
                    timer_d = IDLE_RELOAD;
                end
            end

            ENTRY, CHG_AUTH, CHG_NEW: begin
                if (btstar_i) begin
                    // Every star leaves with an empty buffer; only the target differs.
                    entry_d = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = IDLE;
                    if (state_q == CHG_NEW) begin
                        if (cnt_q == CNT_FULL) begin
                            pw_d   = entry_q;
                            open_d = 1'b1;
                            fail_d = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (match) begin
                        if (state_q == ENTRY) begin
                            open_d = 1'b1;
                            fail_d = '0;
                        end else begin
                            state_d = CHG_NEW;
                            timer_d = IDLE_RELOAD;
                        end
                    end else begin
                        err_d  = 1'b1;
                        fail_d = fail_inc;
                        if (fail_inc >= FAIL_LIM) begin
                            state_d = LOCKOUT;
                            timer_d = LOCK_RELOAD;
                        end
                    end
                end else if (dig) begin
                    timer_d = IDLE_RELOAD;
                    if (cnt_q != CNT_FULL) begin
                        entry_d = (entry_q << DIGIT_W) | BW'(key_bcd);
                        cnt_d   = cnt_q + 4'd1;
                    end
                end else if (timer_q == '0) begin
                    state_d = IDLE;
                    entry_d = '0;
                    cnt_d   = '0;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end

            LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end

            default: begin
                state_d = IDLE;
                entry_d = '0;
                cnt_d   = '0;
                timer_d = '0;
            end
        endcase
    end

    assign open_o  = open_q;
    assign err_o   = err_q;
    assign lock_o  = (state_q == LOCKOUT);
    assign chg_o   = (state_q == CHG_AUTH) || (state_q == CHG_NEW);
    assign cnt_o   = cnt_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Self-checking bench for doorlock_ctrl: event-level reference model plus response scoreboard.
module tb_doorlock_ctrl;

    localparam int PW_LEN   = 4;
    localparam int MAX_FAIL = 3;
    localparam int T_IDLE   = 20;
    localparam int T_LOCK   = 50;

    localparam int S_IDLE  = 0;
    localparam int S_ENTRY = 1;
    localparam int S_AUTH  = 2;
    localparam int S_NEW   = 3;
    localparam int S_LOCK  = 4;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [9:0] bt_i;
    logic       btstar_i;
    logic       open_o, err_o, lock_o, chg_o;
    logic [3:0] cnt_o;
    logic [2:0] state_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int due;
        bit open;
        bit err;
    } exp_t;
    exp_t sb[$];

    // Reference model: mode, typed digits, stored password, failure count, timestamps.
    int m_mode;
    int m_dig[$];
    int m_pw[PW_LEN];
    int m_fails;
    int m_last;
    int m_lock_at;

    doorlock_ctrl #(
        .PW_LEN   (PW_LEN),
        .MAX_FAIL (MAX_FAIL),
        .T_IDLE   (32'd20),
        .T_LOCK   (32'd50),
        .INIT_PW  (16'h1234)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .bt_i     (bt_i),
        .btstar_i (btstar_i),
        .open_o   (open_o),
        .err_o    (err_o),
        .lock_o   (lock_o),
        .chg_o    (chg_o),
        .cnt_o    (cnt_o),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void m_reset();
        m_mode  = S_IDLE;
        m_dig.delete();
        m_pw    = '{1, 2, 3, 4};
        m_fails = 0;
        m_last  = 0;
        m_lock_at = 0;
    endfunction

    // Apply time-driven transitions for the state held after clock edge n.
    function automatic void m_settle(input int n);
        if ((m_mode == S_ENTRY || m_mode == S_AUTH || m_mode == S_NEW) && (n - m_last >= T_IDLE)) begin
            m_mode = S_IDLE;
            m_dig.delete();
        end
        if (m_mode == S_LOCK && (n - m_lock_at >= T_LOCK)) begin
            m_mode  = S_IDLE;
            m_fails = 0;
        end
    endfunction

    function automatic bit m_match();
        if (m_dig.size() != PW_LEN) return 1'b0;
        for (int i = 0; i < PW_LEN; i++)
            if (m_dig[i] != m_pw[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Key captured at clock edge c.
    function automatic void m_key(input logic [9:0] bt, input logic star, input int c);
        exp_t e;
        int   d;
        m_settle(c - 1);
        if (m_mode == S_LOCK) return;
        if (star) begin
            e.due  = c;
            e.open = 1'b0;
            e.err  = 1'b0;
            case (m_mode)
                S_IDLE: begin
                    m_mode = S_AUTH;
                    m_last = c;
                end
                S_ENTRY, S_AUTH: begin
                    if (m_match()) begin
                        if (m_mode == S_ENTRY) begin
                            e.open  = 1'b1;
                            m_fails = 0;
                            m_mode  = S_IDLE;
                        end else begin
                            m_mode = S_NEW;
                            m_last = c;
                        end
                    end else begin
                        e.err = 1'b1;
                        m_fails++;
                        if (m_fails >= MAX_FAIL) begin
                            m_mode    = S_LOCK;
                            m_lock_at = c;
                        end else begin
                            m_mode = S_IDLE;
                        end
                    end
                end
                default: begin
                    if (m_dig.size() == PW_LEN) begin
                        for (int i = 0; i < PW_LEN; i++) m_pw[i] = m_dig[i];
                        e.open  = 1'b1;
                        m_fails = 0;
                    end else begin
                        e.err = 1'b1;
                    end
                    m_mode = S_IDLE;
                end
            endcase
            m_dig.delete();
            sb.push_back(e);
        end else if ($countones(bt) == 1) begin
            d = 0;
            for (int i = 0; i < 10; i++) if (bt[i]) d = i;
            if (m_mode == S_IDLE) begin
                m_dig.delete();
                m_dig.push_back(d);
                m_mode = S_ENTRY;
            end else if (m_dig.size() < PW_LEN) begin
                m_dig.push_back(d);
            end
            m_last = c;
        end
    endfunction

    // One clock cycle: check held state, then present the inputs for the next edge.
    task automatic tick(input logic [9:0] bt, input logic star);
        @(negedge clk);
        m_settle(cyc);
        chk("state_o", int'(state_o), m_mode);
        chk("cnt_o", int'(cnt_o), m_dig.size());
        chk("lock_o", int'(lock_o), int'(m_mode == S_LOCK));
        chk("chg_o", int'(chg_o), int'(m_mode == S_AUTH || m_mode == S_NEW));
        bt_i     = bt;
        btstar_i = star;
        m_key(bt, star, cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(10'd0, 1'b0);
    endtask

    task automatic enter(input string s);
        int d;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "*") begin
                tick(10'd0, 1'b1);
            end else begin
                d = int'(s[i]) - 48;
                tick(10'd1 << d, 1'b0);
            end
            tick(10'd0, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        bt_i     = '0;
        btstar_i = 1'b0;
        n_rst    = 1'b0;
        #1;
        chk("rst_open", int'(open_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_lock", int'(lock_o), 0);
        chk("rst_chg", int'(chg_o), 0);
        chk("rst_cnt", int'(cnt_o), 0);
        chk("rst_state", int'(state_o), S_IDLE);
        m_reset();
        sb.delete();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
    endtask

    // Response monitor: compares open/err pulses against the scoreboard.
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                void'(sb.pop_front());
                chk("resp_missed", 1, 0);
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                chk("open_o", int'(open_o), int'(sb[0].open));
                chk("err_o", int'(err_o), int'(sb[0].err));
                void'(sb.pop_front());
            end else if (open_o !== 1'b0 || err_o !== 1'b0) begin
                chk("spurious_pulse", int'({open_o, err_o}), 0);
            end
        end
    end

    initial begin
        logic [9:0] v;
        int         n;
        n_rst    = 1'b0;
        bt_i     = '0;
        btstar_i = 1'b0;
        m_reset();
        do_reset();

        // Correct code.
        enter("1234*");
        idle(2);
        // Three failures, attempts during lockout, recovery with cleared fail count.
        enter("9999*");
        enter("9999*");
        enter("9999*");
        enter("1234*");
        idle(T_LOCK);
        enter("99*");
        enter("99*");
        enter("1234*");
        // Short and over-long entries.
        enter("123*");
        enter("12345*");
        // Password change, then old/new codes, then reset restores the initial code.
        enter("*1234*5678*");
        enter("1234*");
        enter("5678*");
        do_reset();
        enter("1234*");
        // Inactivity timeout keeps nothing and emits nothing.
        enter("12");
        idle(T_IDLE + 3);
        enter("34*");
        // Multi-bit digit ignored, digit+star collision, reset while in ENTRY.
        tick(10'b00_0000_0011, 1'b0);
        tick(10'd1 << 5, 1'b1);
        idle(T_IDLE + 3);
        enter("1");
        do_reset();
        enter("1234*");

        // Randomised traffic.
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 7))
                0, 1: begin
                    for (int i = 0; i < PW_LEN; i++) tick(10'd1 << m_pw[i], 1'b0);
                    tick(10'd0, 1'b1);
                end
                2: begin
                    n = $urandom_range(1, 6);
                    for (int i = 0; i < n; i++) tick(10'd1 << $urandom_range(0, 9), 1'b0);
                    tick(10'd0, 1'b1);
                end
                3: tick(10'd0, 1'b1);
                4: begin
                    v = 10'($urandom_range(1, 1023));
                    if ($countones(v) < 2) v = v | 10'b11;
                    tick(v, 1'b0);
                end
                5: tick(10'd1 << $urandom_range(0, 9), 1'b1);
                6: idle($urandom_range(T_IDLE - 2, T_IDLE + 2));
                default: begin
                    if (m_mode == S_LOCK) idle(T_LOCK);
                    else tick(10'd1 << $urandom_range(0, 9), 1'b0);
                end
            endcase
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 59) == 0) do_reset();
        end

        idle(3);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
